adder_resp_checker: RTL and testbench
=====================================

ADDER_RESP_CHECKER -- requirements
Module: adder_resp_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, meaning operand and sum width in bits (1..3).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning cycles from operand presentation to valid {c_out,s_out} (1..8).
REQ-003 The block SHALL have parameter NUM_CHECKS, default 200, meaning comparisons per run (1..255).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a run.
REQ-007 in_a  input  WIDTH  operand A, as presented to the adder under test.
REQ-008 in_b  input  WIDTH  operand B, as presented to the adder under test.
REQ-009 s_out  input  WIDTH  sum returned by the adder under test.
REQ-010 c_out  input  1  carry returned by the adder under test.
REQ-011 busy  output  1  high in FILL or CHECK.
REQ-012 done  output  1  high in DONE.
REQ-013 err_flag  output  1  sticky; set on the first mismatch of a run.
REQ-014 err_cnt  output  8  mismatch count for the current run.
REQ-015 chk_cnt  output  8  comparisons performed in the current run.

Function
REQ-016 Expected value SHALL be the (WIDTH+1)-bit sum in_a+in_b, zero-extended with no truncation, so carry equals bit WIDTH.
REQ-017 Expected values SHALL pass through a LATENCY-deep shift register that advances every cycle in every state, so the expected value compared at cycle n is that of operands sampled at cycle n-LATENCY.
REQ-018 The FSM SHALL have four states: IDLE, FILL, CHECK, DONE.
REQ-019 IDLE -> FILL on start; all other inputs are ignored in IDLE.
REQ-020 Entering FILL SHALL clear err_cnt, chk_cnt and err_flag.
REQ-021 FILL SHALL last exactly LATENCY cycles, counted by an internal fill counter, then move to CHECK.
REQ-022 In CHECK, each cycle SHALL compare {c_out,s_out} with the delay-line output and increment chk_cnt by 1.
REQ-023 On a CHECK mismatch, err_cnt SHALL increment, saturating at 255, and err_flag SHALL be set.
REQ-024 CHECK -> DONE in the cycle in which chk_cnt reaches NUM_CHECKS; no comparison SHALL occur after that.
REQ-025 DONE SHALL hold err_cnt, chk_cnt and err_flag stable; start in DONE SHALL go to FILL, which clears them.
REQ-026 start asserted in FILL or CHECK SHALL be ignored; the run continues unchanged.
REQ-027 X or Z on s_out or c_out during CHECK SHALL count as a mismatch, using a case-inequality comparison in simulation.
REQ-028 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, busy 0, done 0, err_flag 0, err_cnt 0, chk_cnt 0, delay line all zeros, fill counter 0.
REQ-030 Reset asserted mid-run SHALL abort the run with no partial results retained; after release the block waits in IDLE for start.
REQ-031 Release of rst_n SHALL take effect at the next rising edge of clk.

Verification
REQ-032 Correct adder, LATENCY=2, WIDTH=1, start pulse, operands cycling 00/10/01/11 -> busy for 202 cycles, then done=1, chk_cnt=200, err_cnt=0, err_flag=0.
REQ-033 Adder with c_out stuck at 0, same stimulus -> done with err_flag=1 and err_cnt=50, which is every 11 case.
REQ-034 WIDTH=3, operands 7+7, correct adder -> expected 4'b1110 matched, err_cnt=0; same with s_out bit0 forced to 1 -> err_cnt=NUM_CHECKS.
REQ-035 Always-mismatching adder, NUM_CHECKS=255 -> err_cnt=255 at done, with saturation never exceeding 255.
REQ-036 rst_n pulsed low at chk_cnt=37 -> all outputs 0 during reset and state IDLE; a later start gives a full clean run.
REQ-037 start re-pulsed during CHECK -> no restart, chk_cnt continues; start in DONE -> counters clear and a new run begins.

Source files
------------

// File: rtl/adder_resp_checker.sv
// Checks the {carry,sum} returned by an adder under test against the
// operand sum, delayed to match the adder's latency, over one run of checks.
module adder_resp_checker #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned NUM_CHECKS = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] s_out,
  input  logic             c_out,
  output logic             busy,
  output logic             done,
  output logic             err_flag,
  output logic [7:0]       err_cnt,
  output logic [7:0]       chk_cnt
);

  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_e;

  state_e       state_q, state_d;
  logic [3:0]   fill_q, fill_d;
  logic [WIDTH:0] dl_q [LATENCY];
  logic [WIDTH:0] dl_d [LATENCY];
  logic [7:0]   err_cnt_q, err_cnt_d;
  logic [7:0]   chk_cnt_q, chk_cnt_d;
  logic         err_flag_q, err_flag_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         mismatch;

  // Case inequality so that X/Z on the adder response counts as a mismatch.
  assign mismatch = ({c_out, s_out} !== dl_q[LATENCY-1]);

  always_comb begin
    dl_d[0] = {1'b0, in_a} + {1'b0, in_b};
    for (int unsigned i = 1; i < LATENCY; i++) begin
      dl_d[i] = dl_q[i-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    err_cnt_d  = err_cnt_q;
    chk_cnt_d  = chk_cnt_q;
    err_flag_d = err_flag_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = FILL;
          fill_d     = '0;
          err_cnt_d  = '0;
          chk_cnt_d  = '0;
          err_flag_d = 1'b0;
        end
      end
      FILL: begin
        if (fill_q == 4'(LATENCY - 1)) begin
          state_d = CHECK;
          fill_d  = '0;
        end else begin
          fill_d = fill_q + 4'd1;
        end
      end
      CHECK: begin
        chk_cnt_d = chk_cnt_q + 8'd1;
        if (mismatch) begin
          err_flag_d = 1'b1;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
        if (chk_cnt_q + 8'd1 == 8'(NUM_CHECKS)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == FILL) || (state_d == CHECK);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fill_q     <= '0;
      err_cnt_q  <= '0;
      chk_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        dl_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      err_cnt_q  <= err_cnt_d;
      chk_cnt_q  <= chk_cnt_d;
      err_flag_q <= err_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        dl_q[i] <= dl_d[i];
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err_flag = err_flag_q;
  assign err_cnt  = err_cnt_q;
  assign chk_cnt  = chk_cnt_q;

endmodule

// File: tb/tb_adder_resp_checker.sv
// Directed bench: three checker configurations, each fed by a small
// behavioural adder with selectable faults.
module tb_adder_resp_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int tests = 0;
  int fails = 0;
  int op_idx = 0;

  // Instance A: WIDTH=1, LATENCY=2, NUM_CHECKS=200
  logic start_a, a_a, b_a, s_a, c_a, busy_a, done_a, flag_a, fault_a;
  logic [7:0] errc_a, chkc_a;
  logic [1:0] pa [2];
  // Instance B: WIDTH=3, LATENCY=3, NUM_CHECKS=20
  logic start_b, c_b, busy_b, done_b, flag_b, fault_b;
  logic [2:0] a_b, b_b, s_b;
  logic [7:0] errc_b, chkc_b;
  logic [3:0] pb [3];
  // Instance C: WIDTH=2, LATENCY=1, NUM_CHECKS=255, always wrong
  logic start_c, c_c, busy_c, done_c, flag_c;
  logic [1:0] a_c, b_c, s_c;
  logic [7:0] errc_c, chkc_c;
  logic [2:0] pc;

  always @(posedge clk) begin
    pa[0] <= {1'b0, a_a} + {1'b0, b_a};
    pa[1] <= pa[0];
    pb[0] <= {1'b0, a_b} + {1'b0, b_b};
    pb[1] <= pb[0];
    pb[2] <= pb[1];
    pc    <= {1'b0, a_c} + {1'b0, b_c};
  end

  assign s_a = pa[1][0];
  assign c_a = fault_a ? 1'b0 : pa[1][1];
  assign s_b = pb[2][2:0] | (fault_b ? 3'b001 : 3'b000);
  assign c_b = pb[2][3];
  assign {c_c, s_c} = ~pc;

  adder_resp_checker #(.WIDTH(1), .LATENCY(2), .NUM_CHECKS(200)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_a(a_a), .in_b(b_a),
    .s_out(s_a), .c_out(c_a), .busy(busy_a), .done(done_a),
    .err_flag(flag_a), .err_cnt(errc_a), .chk_cnt(chkc_a));

  adder_resp_checker #(.WIDTH(3), .LATENCY(3), .NUM_CHECKS(20)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_a(a_b), .in_b(b_b),
    .s_out(s_b), .c_out(c_b), .busy(busy_b), .done(done_b),
    .err_flag(flag_b), .err_cnt(errc_b), .chk_cnt(chkc_b));

  adder_resp_checker #(.WIDTH(2), .LATENCY(1), .NUM_CHECKS(255)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .in_a(a_c), .in_b(b_c),
    .s_out(s_c), .c_out(c_c), .busy(busy_c), .done(done_c),
    .err_flag(flag_c), .err_cnt(errc_c), .chk_cnt(chkc_c));

  task automatic check_eq(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Operands for A cycle (a,b) = 00,10,01,11 every cycle.
  task automatic step();
    @(negedge clk);
    op_idx = (op_idx + 1) % 4;
    a_a = (op_idx == 1) || (op_idx == 3);
    b_a = (op_idx >= 2);
  endtask

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic pulse(input int sel);
    case (sel)
      0:       start_a = 1'b1;
      1:       start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic run_len(input int sel, output int n);
    n = 0;
    while (busy_of(sel) && n < 2000) begin
      n++;
      step();
    end
  endtask

  task automatic wait_chk_a(input int target);
    int g = 0;
    while (int'(chkc_a) != target && g < 1000) begin
      g++;
      step();
    end
    check_eq("wait_chk_a", int'(chkc_a), target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    fault_a = 1'b0; fault_b = 1'b0;
    a_a = 1'b0; b_a = 1'b0;
    a_b = 3'd7; b_b = 3'd7;
    a_c = 2'd1; b_c = 2'd2;
    repeat (3) step();
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_flag", flag_a, 0);
    check_eq("rst_err", errc_a, 0);
    check_eq("rst_chk", chkc_a, 0);
    rst_n = 1'b1;
    repeat (3) step();
    check_eq("idle_wait_busy", busy_a, 0);

    // Correct adder, full run
    pulse(0);
    run_len(0, n);
    check_eq("a_busy_len", n, 202);
    check_eq("a_done", done_a, 1);
    check_eq("a_chk", chkc_a, 200);
    check_eq("a_err", errc_a, 0);
    check_eq("a_flag", flag_a, 0);

    // c_out stuck at 0: only the 1+1 case fails
    fault_a = 1'b1;
    pulse(0);
    run_len(0, n);
    check_eq("stuck_busy_len", n, 202);
    check_eq("stuck_done", done_a, 1);
    check_eq("stuck_chk", chkc_a, 200);
    check_eq("stuck_err", errc_a, 50);
    check_eq("stuck_flag", flag_a, 1);

    // Reset mid-run with errors already accumulated
    pulse(0);
    wait_chk_a(37);
    check_eq("pre_rst_flag", flag_a, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy_a, 0);
    check_eq("mid_rst_done", done_a, 0);
    check_eq("mid_rst_flag", flag_a, 0);
    check_eq("mid_rst_err", errc_a, 0);
    check_eq("mid_rst_chk", chkc_a, 0);
    step();
    step();
    rst_n = 1'b1;
    fault_a = 1'b0;
    repeat (4) step();
    check_eq("post_rst_idle_busy", busy_a, 0);
    check_eq("post_rst_idle_done", done_a, 0);
    pulse(0);
    run_len(0, n);
    check_eq("post_rst_len", n, 202);
    check_eq("post_rst_chk", chkc_a, 200);
    check_eq("post_rst_err", errc_a, 0);
    check_eq("post_rst_flag", flag_a, 0);

    // start during CHECK is ignored; start in DONE restarts
    pulse(0);
    wait_chk_a(50);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check_eq("restart_ign_chk", chkc_a, 51);
    check_eq("restart_ign_busy", busy_a, 1);
    run_len(0, n);
    check_eq("restart_ign_rest", n, 149);
    check_eq("restart_ign_done", done_a, 1);
    repeat (5) step();
    check_eq("done_hold_chk", chkc_a, 200);
    check_eq("done_hold_done", done_a, 1);
    check_eq("done_hold_busy", busy_a, 0);
    fault_a = 1'b1;
    pulse(0);
    check_eq("rerun_busy", busy_a, 1);
    check_eq("rerun_done", done_a, 0);
    check_eq("rerun_chk", chkc_a, 0);
    run_len(0, n);
    check_eq("rerun_len", n, 202);
    check_eq("rerun_err", errc_a, 50);
    fault_a = 1'b0;

    // WIDTH=3, 7+7 = 4'b1110
    pulse(1);
    run_len(1, n);
    check_eq("w3_len", n, 23);
    check_eq("w3_done", done_b, 1);
    check_eq("w3_chk", chkc_b, 20);
    check_eq("w3_err", errc_b, 0);
    check_eq("w3_flag", flag_b, 0);
    fault_b = 1'b1;
    pulse(1);
    run_len(1, n);
    check_eq("w3_fault_chk", chkc_b, 20);
    check_eq("w3_fault_err", errc_b, 20);
    check_eq("w3_fault_flag", flag_b, 1);

    // Always wrong, 255 checks: err_cnt saturates exactly at 255
    pulse(2);
    run_len(2, n);
    check_eq("sat_len", n, 256);
    check_eq("sat_done", done_c, 1);
    check_eq("sat_chk", chkc_c, 255);
    check_eq("sat_err", errc_c, 255);
    check_eq("sat_flag", flag_c, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
